// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencing controller.
// States, major opcodes, ALU/rd-select codes and the datapath control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] RDSEL_ALU = 2'b00;
    localparam logic [1:0] RDSEL_PC  = 2'b01;
    localparam logic [1:0] RDSEL_PC4 = 2'b10;
    localparam logic [1:0] RDSEL_IMM = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
        logic [1:0] rd_sel;
        logic       pc_gen_sel;
        logic       mem_read;
        logic       mem_write;
        logic       muldiv;
    } ctrl_bundle_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between the controller and memories.
// The controller drives requests; memories answer with ready.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational major-opcode decoder producing the control bundle.
// MULDIV_EN: R-type with funct7_0 set is flagged as multiply/divide.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    input  logic         funct7_0,
    output ctrl_bundle_t bundle,
    output logic         illegal,
    output logic         sys
);

`ifndef MULDIV_EN
    logic unused_f7;
    assign unused_f7 = funct7_0;
`endif

    // One-hot opcode match; anything unlisted is illegal
    always_comb begin
        bundle  = '0;
        illegal = 1'b0;
        sys     = 1'b0;
        unique case (1'b1)
            (opcode == OPC_R): begin
                bundle.reg_write = 1'b1;
                bundle.alu_op    = ALUOP_R;
`ifdef MULDIV_EN
                bundle.muldiv    = funct7_0;
`endif
            end
            (opcode == OPC_LOAD): begin
                bundle.mem_to_reg = 1'b1;
                bundle.alu_src    = 1'b1;
                bundle.reg_write  = 1'b1;
                bundle.mem_read   = 1'b1;
            end
            (opcode == OPC_STORE): begin
                bundle.alu_src   = 1'b1;
                bundle.mem_write = 1'b1;
            end
            (opcode == OPC_BRANCH): begin
                bundle.branch = 1'b1;
                bundle.alu_op = ALUOP_BR;
            end
            (opcode == OPC_OPIMM): begin
                bundle.alu_src   = 1'b1;
                bundle.reg_write = 1'b1;
                bundle.alu_op    = ALUOP_I;
            end
            (opcode == OPC_JALR): begin
                bundle.reg_write  = 1'b1;
                bundle.rd_sel     = RDSEL_PC4;
                bundle.pc_gen_sel = 1'b1;
            end
            (opcode == OPC_JAL): begin
                bundle.reg_write = 1'b1;
                bundle.rd_sel    = RDSEL_PC4;
            end
            (opcode == OPC_AUIPC): begin
                bundle.reg_write = 1'b1;
                bundle.rd_sel    = RDSEL_PC;
            end
            (opcode == OPC_LUI): begin
                bundle.reg_write = 1'b1;
                bundle.rd_sel    = RDSEL_IMM;
            end
            (opcode == OPC_SYSTEM): sys = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and traps.
// MULDIV_EN: EXEC waits on muldiv_done for flagged R-type instructions.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        opcode,
    input  logic              funct7_0,
    input  logic              muldiv_done,
    multicycle_ctrl_if.master mem,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write_en,
    output logic              branch,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              pc_gen_sel,
    output logic              muldiv_start,
    output logic [1:0]        alu_op,
    output logic [1:0]        rd_sel,
    output logic              retire,
    output logic              halted,
    output logic              illegal,
    output logic              bus_err,
    output logic [2:0]        state
);

    localparam logic [2:0] ST_FETCH  = S_FETCH;
    localparam logic [2:0] ST_DECODE = S_DECODE;
    localparam logic [2:0] ST_EXEC   = S_EXEC;
    localparam logic [2:0] ST_MEM    = S_MEM;
    localparam logic [2:0] ST_WB     = S_WB;
    localparam logic [2:0] ST_HALT   = S_HALT;
    localparam logic [2:0] ST_ERR    = S_ERR;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    logic [2:0]   state_q, state_d;
    logic [CW-1:0] wd_cnt;
    ctrl_bundle_t dec_b, ctrl_q;
    logic         dec_ill, dec_sys;
    logic         wait_cyc, wd_hit;
    logic         in_fetch, in_decode, in_exec, in_mem, in_wb;
    logic         st_done;

    ctrl_decoder u_dec (
        .opcode   (opcode),
        .funct7_0 (funct7_0),
        .bundle   (dec_b),
        .illegal  (dec_ill),
        .sys      (dec_sys)
    );

    assign in_fetch  = (state_q == ST_FETCH);
    assign in_decode = (state_q == ST_DECODE);
    assign in_exec   = (state_q == ST_EXEC);
    assign in_mem    = (state_q == ST_MEM);
    assign in_wb     = (state_q == ST_WB);
    assign wd_hit    = (wd_cnt == WD_LAST);

    // Next state; wait_cyc marks a cycle spent waiting on a ready/done
    always_comb begin
        state_d  = state_q;
        wait_cyc = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem.imem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    wait_cyc = 1'b1;
                    if (wd_hit) state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                if (dec_sys)      state_d = ST_HALT;
                else if (dec_ill) state_d = ST_ERR;
                else              state_d = ST_EXEC;
            end
            ST_EXEC: begin
`ifdef MULDIV_EN
                if (ctrl_q.muldiv && !muldiv_done) begin
                    wait_cyc = 1'b1;
                    if (wd_hit) state_d = ST_ERR;
                end else
`endif
                if (ctrl_q.mem_read || ctrl_q.mem_write) state_d = ST_MEM;
                else                                     state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem.dmem_ready) begin
                    state_d = ctrl_q.mem_read ? ST_WB : ST_FETCH;
                end else begin
                    wait_cyc = 1'b1;
                    if (wd_hit) state_d = ST_ERR;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Watchdog restarts on every state change, counts wait cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  wd_cnt <= '0;
        else if (state_d != state_q) wd_cnt <= '0;
        else if (wait_cyc)           wd_cnt <= wd_cnt + CW'(1);
    end

    // Bundle captured once in DECODE and held until the next DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         ctrl_q <= '0;
        else if (in_decode) ctrl_q <= dec_b;
    end

    // Sticky status, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (in_decode && dec_sys) halted  <= 1'b1;
            if (in_decode && dec_ill) illegal <= 1'b1;
            if (wait_cyc && wd_hit)   bus_err <= 1'b1;
        end
    end

    // Strobes also drop while rst_n is low since FETCH is the reset state
    assign st_done      = in_mem && ctrl_q.mem_write && mem.dmem_ready;
    assign mem.imem_req = rst_n && in_fetch;
    assign ir_write     = rst_n && in_fetch && mem.imem_ready;
    assign mem.dmem_req = rst_n && in_mem;
    assign mem.dmem_we  = rst_n && in_mem && ctrl_q.mem_write;
    assign pc_write     = rst_n && (in_wb || st_done);
    assign retire       = rst_n && (in_wb || st_done);
    assign reg_write_en = rst_n && in_wb && ctrl_q.reg_write;

`ifdef MULDIV_EN
    assign muldiv_start = rst_n && in_exec && ctrl_q.muldiv
                          && (wd_cnt == '0);
`else
    logic unused_md;
    assign unused_md    = muldiv_done ^ ctrl_q.muldiv ^ in_exec;
    assign muldiv_start = 1'b0;
`endif

    assign branch     = ctrl_q.branch;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src    = ctrl_q.alu_src;
    assign pc_gen_sel = ctrl_q.pc_gen_sel;
    assign alu_op     = ctrl_q.alu_op;
    assign rd_sel     = ctrl_q.rd_sel;
    assign state      = state_q;

endmodule
